// File: rtl/decoder_gate_pkg.sv
// decoder_gate_pkg: shared sizes and pipeline latency for decoder_gate.
// Build option: DECODER_GATE_INREG_EN adds an input register stage (latency 2).
package decoder_gate_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 2 ** SEL_W;

`ifdef DECODER_GATE_INREG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/decoder_gate_core.sv
// decoder_gate_core: combinational enable-gated binary-to-one-hot decode.
// Each output is a single AND of e with the true/complemented select bits.
module decoder_gate_core #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      a,
  input  logic                  e,
  output logic [(2**SEL_W)-1:0] d
);

  localparam int OUT_W = 2 ** SEL_W;

  // Per-output minterm: bit j of the index picks a[j] or ~a[j].
  for (genvar i = 0; i < OUT_W; i++) begin : g_out
    logic [SEL_W-1:0] lit;
    for (genvar j = 0; j < SEL_W; j++) begin : g_bit
      if (((i >> j) & 1) == 1) begin : g_true
        assign lit[j] = a[j];
      end else begin : g_comp
        assign lit[j] = ~a[j];
      end
    end
    assign d[i] = e & (&lit);
  end

endmodule

// File: rtl/decoder_gate.sv
// decoder_gate: registered one-hot decoder with enable and valid flag.
// Build option: DECODER_GATE_INREG_EN registers a/e before the decode,
// giving 2-cycle latency instead of 1. Ports are identical in both builds.
module decoder_gate #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      a,
  input  logic                  e,
  output logic [(2**SEL_W)-1:0] d,
  output logic                  vld
);

  import decoder_gate_pkg::*;

  localparam int OUT_W_L = 2 ** SEL_W;

  logic [SEL_W-1:0]   a_dec;
  logic               e_dec;
  logic [OUT_W_L-1:0] d_comb;

`ifdef DECODER_GATE_INREG_EN
  logic [SEL_W-1:0] a_q;
  logic             e_q;

  // Input stage: capture select and enable; reset clears to a=0, e=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      e_q <= 1'b0;
    end else begin
      a_q <= a;
      e_q <= e;
    end
  end

  assign a_dec = a_q;
  assign e_dec = e_q;
`else
  assign a_dec = a;
  assign e_dec = e;
`endif

  decoder_gate_core #(
    .SEL_W (SEL_W)
  ) u_core (
    .a (a_dec),
    .e (e_dec),
    .d (d_comb)
  );

  // Output stage: d and vld come from the same decode pair, so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= '0;
      vld <= 1'b0;
    end else begin
      d   <= d_comb;
      vld <= e_dec;
    end
  end

endmodule

// File: tb/tb_decoder_gate.sv
// tb_decoder_gate: directed test of decoder_gate in either build.
module tb_decoder_gate;
  import decoder_gate_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] a;
  logic       e;
  logic [7:0] d;
  logic       vld;

  int total = 0;
  int bad   = 0;

  logic [7:0] hist_d [0:1];
  logic       hist_v [0:1];
  string      hist_t [0:1];
  int         nvalid = 0;

  decoder_gate dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .e     (e),
    .d     (d),
    .vld   (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_d(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s d got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic chk_v(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s vld got=%b want=%b", tag, got, want);
    end
  endtask

  // Called at a negedge: drive a vector, record its expected result, step one
  // cycle, then compare the vector that is now LATENCY cycles old.
  task automatic cyc(input logic [2:0] av, input logic ev,
                     input logic [7:0] xd, input logic xv, input string tag);
    logic onehot0;
    a = av;
    e = ev;
    hist_d[1] = hist_d[0];
    hist_v[1] = hist_v[0];
    hist_t[1] = hist_t[0];
    hist_d[0] = xd;
    hist_v[0] = xv;
    hist_t[0] = tag;
    nvalid++;
    @(posedge clk);
    #1;
    if (nvalid >= LATENCY) begin
      chk_d(hist_t[LATENCY-1], d, hist_d[LATENCY-1]);
      chk_v(hist_t[LATENCY-1], vld, hist_v[LATENCY-1]);
    end
    onehot0 = ((d & (d - 8'd1)) == 8'd0);
    total++;
    assert (onehot0 && (d == 8'd0 || vld)) else begin
      bad++;
      $error("FAIL invariant d=%h vld=%b", d, vld);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    a = 3'd3;
    e = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    chk_d("reset_async", d, 8'h00);
    chk_v("reset_async", vld, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_d("reset_held", d, 8'h00);
    chk_v("reset_held", vld, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(3'd0, 1'b1, 8'h01, 1'b1, "sweep0");
    cyc(3'd1, 1'b1, 8'h02, 1'b1, "sweep1");
    cyc(3'd2, 1'b1, 8'h04, 1'b1, "sweep2");
    cyc(3'd3, 1'b1, 8'h08, 1'b1, "sweep3");
    cyc(3'd4, 1'b1, 8'h10, 1'b1, "sweep4");
    cyc(3'd5, 1'b1, 8'h20, 1'b1, "sweep5");
    cyc(3'd6, 1'b1, 8'h40, 1'b1, "sweep6");
    cyc(3'd7, 1'b1, 8'h80, 1'b1, "sweep7");
    cyc(3'd5, 1'b0, 8'h00, 1'b0, "disable_a5");
    cyc(3'd2, 1'b0, 8'h00, 1'b0, "disable_a2");
    cyc(3'd7, 1'b1, 8'h80, 1'b1, "b2b_a7");
    cyc(3'd0, 1'b1, 8'h01, 1'b1, "b2b_a0");
    cyc(3'd6, 1'b1, 8'h40, 1'b1, "efall_pre");
    cyc(3'd6, 1'b0, 8'h00, 1'b0, "efall");
    cyc(3'd1, 1'b1, 8'h02, 1'b1, "pair_rise");
    cyc(3'd4, 1'b1, 8'h10, 1'b1, "pre_rst_a");
    cyc(3'd4, 1'b1, 8'h10, 1'b1, "pre_rst_b");

    // d now shows 10 in either build; pulse reset between edges.
    chk_d("pre_rst_d", d, 8'h10);
    a = 3'd2;
    rst_n = 1'b0;
    #1;
    chk_d("midrst", d, 8'h00);
    chk_v("midrst", vld, 1'b0);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    @(negedge clk);

    cyc(3'd2, 1'b1, 8'h04, 1'b1, "post_rst0");
    cyc(3'd3, 1'b1, 8'h08, 1'b1, "post_rst1");
    cyc(3'd0, 1'b0, 8'h00, 1'b0, "drain0");
    cyc(3'd0, 1'b0, 8'h00, 1'b0, "drain1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
